// File: rtl/tcam_search_engine_if.sv
// Table-write port plus search/result valid-ready handshake of the TCAM search engine.
// master = client driving writes and searches, slave = the engine.
interface tcam_search_engine_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
);
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_value;
    logic [WIDTH-1:0] wr_mask;
    logic             wr_valid;
    logic             clear_all;

    logic             search_valid;
    logic [WIDTH-1:0] search_key;
    logic             search_ready;

    logic             result_valid;
    logic             result_ready;
    logic             result_hit;
    logic [IDX_W-1:0] result_index;
    logic [DEPTH-1:0] result_match;

    modport master (
        output wr_en, wr_addr, wr_value, wr_mask, wr_valid, clear_all,
        output search_valid, search_key, result_ready,
        input  search_ready, result_valid, result_hit, result_index, result_match
    );

    modport slave (
        input  wr_en, wr_addr, wr_value, wr_mask, wr_valid, clear_all,
        input  search_valid, search_key, result_ready,
        output search_ready, result_valid, result_hit, result_index, result_match
    );
endinterface

// File: rtl/tcam_search_engine.sv
// Ternary CAM: DEPTH value/mask/valid rules searched in parallel, with the match vector and
// lowest-index hit returned through a 2-stage valid/ready pipeline.
module tcam_search_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tcam_search_engine_if.slave  bus
);
    localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

    logic [WIDTH-1:0] value_q [DEPTH];
    logic [WIDTH-1:0] mask_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [DEPTH-1:0] match_vec;
    logic [DEPTH-1:0] s1_match;
    logic             s1_valid;
    logic             stall;
    logic             accept;
    logic             enc_hit;
    logic [IDX_W-1:0] enc_index;

    // Both stages freeze together while a produced result is not taken.
    assign stall            = bus.result_valid & ~bus.result_ready;
    assign bus.search_ready = ~stall;
    assign accept           = bus.search_valid & ~stall;

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid_q[i] && (((bus.search_key ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    always_comb begin
        enc_hit   = |s1_match;
        enc_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                enc_index = IDX_W'(i);
            end
        end
    end

    // Table writes ignore backpressure; clear_all wins over a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '0;
            end
        end else if (bus.clear_all) begin
            valid_q <= '0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_LIM)) begin
            value_q[bus.wr_addr] <= bus.wr_value;
            mask_q[bus.wr_addr]  <= bus.wr_mask;
            valid_q[bus.wr_addr] <= bus.wr_valid;
        end
    end

    // Stage 1 snapshots the match vector from the pre-edge table; stage 2 encodes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid         <= 1'b0;
            s1_match         <= '0;
            bus.result_valid <= 1'b0;
            bus.result_hit   <= 1'b0;
            bus.result_index <= '0;
            bus.result_match <= '0;
        end else if (!stall) begin
            s1_valid         <= accept;
            bus.result_valid <= s1_valid;
            if (accept) begin
                s1_match <= match_vec;
            end
            if (s1_valid) begin
                bus.result_hit   <= enc_hit;
                bus.result_index <= enc_index;
                bus.result_match <= s1_match;
            end
        end
    end
endmodule

// File: tb/tb_tcam_search_engine.sv
// Bench for tcam_search_engine: directed cases plus randomized traffic scored against a
// cycle-level reference model of the rule table and the result stream.
module tb_tcam_search_engine;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    typedef struct {
        logic [DEPTH-1:0] match;
        int               acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    logic [WIDTH-1:0] m_value [DEPTH];
    logic [WIDTH-1:0] m_mask  [DEPTH];
    logic             m_valid [DEPTH];
    exp_t             exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    tcam_search_engine_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    tcam_search_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DEPTH-1:0] modelMatch(input logic [WIDTH-1:0] key);
        logic [DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && ((key & m_mask[i]) == (m_value[i] & m_mask[i]))) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic int lowestIndex(input logic [DEPTH-1:0] m);
        for (int i = 0; i < DEPTH; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // Reference: results leave in acceptance order, earliest one edge after the accept edge.
    always @(negedge clk) begin : monitor
        logic exp_rv;
        logic exp_sr;
        exp_t item;
        if (!rst_n) begin
            checkOutput("rst_result_valid", 32'(bus.result_valid), 32'd0);
            checkOutput("rst_result_hit", 32'(bus.result_hit), 32'd0);
            checkOutput("rst_result_index", 32'(bus.result_index), 32'd0);
            checkOutput("rst_result_match", 32'(bus.result_match), 32'd0);
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_value[i] = '0;
                m_mask[i]  = '0;
                m_valid[i] = 1'b0;
            end
        end else begin
            exp_rv = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].acc + 1);
            exp_sr = !(exp_rv && !bus.result_ready);
            checkOutput("result_valid", 32'(bus.result_valid), 32'(exp_rv));
            checkOutput("search_ready", 32'(bus.search_ready), 32'(exp_sr));
            if (exp_rv) begin
                checkOutput("result_match", 32'(bus.result_match), 32'(exp_q[0].match));
                checkOutput("result_hit", 32'(bus.result_hit), 32'(exp_q[0].match != '0));
                checkOutput("result_index", 32'(bus.result_index), 32'(lowestIndex(exp_q[0].match)));
                if (bus.result_ready) void'(exp_q.pop_front());
            end
            if (bus.search_valid && exp_sr) begin
                item.match = modelMatch(bus.search_key);
                item.acc   = edge_cnt + 1;
                exp_q.push_back(item);
            end
            if (bus.clear_all) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            end else if (bus.wr_en && int'(bus.wr_addr) < DEPTH) begin
                m_value[bus.wr_addr] = bus.wr_value;
                m_mask[bus.wr_addr]  = bus.wr_mask;
                m_valid[bus.wr_addr] = bus.wr_valid;
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] wa, input logic [WIDTH-1:0] wv,
                                 input logic [WIDTH-1:0] wm, input logic wval, input logic clr,
                                 input logic sv, input logic [WIDTH-1:0] key, input logic rr);
        @(posedge clk);
        #1;
        bus.wr_en        = we;
        bus.wr_addr      = wa;
        bus.wr_value     = wv;
        bus.wr_mask      = wm;
        bus.wr_valid     = wval;
        bus.clear_all    = clr;
        bus.search_valid = sv;
        bus.search_key   = key;
        bus.result_ready = rr;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic searchKey(input logic [WIDTH-1:0] key);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, key, 1'b1);
    endtask

    task automatic waitResult(input string tag, input int bound, input logic hit,
                              input logic [IDX_W-1:0] idx, input logic [DEPTH-1:0] match);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.result_valid && waited < bound);
        if (!bus.result_valid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_hit"}, 32'(bus.result_hit), 32'(hit));
            checkOutput({tag, "_index"}, 32'(bus.result_index), 32'(idx));
            checkOutput({tag, "_match"}, 32'(bus.result_match), 32'(match));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic             r_we, r_wval, r_clr, r_sv, r_rr;
        logic [IDX_W-1:0] r_wa;
        logic [WIDTH-1:0] r_wv, r_wm, r_key;
        int               j;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_value = '0; bus.wr_mask = '0;
        bus.wr_valid = 1'b0; bus.clear_all = 1'b0; bus.search_valid = 1'b0;
        bus.search_key = '0; bus.result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        searchKey(8'h5A);
        idleCycle();
        waitResult("empty_5a", 2, 1'b0, 3'd0, 8'h00);

        applyStimulus(1'b1, 3'd3, 8'hA0, 8'hF0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        searchKey(8'hA7);
        idleCycle();
        waitResult("key_a7", 2, 1'b1, 3'd3, 8'h48);
        searchKey(8'h17);
        idleCycle();
        waitResult("key_17", 2, 1'b1, 3'd6, 8'h40);

        applyStimulus(1'b1, 3'd1, 8'h17, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1);
        idleCycle();
        waitResult("collide_old", 2, 1'b1, 3'd6, 8'h40);
        searchKey(8'h17);
        idleCycle();
        waitResult("collide_new", 2, 1'b1, 3'd1, 8'h42);

        searchKey(8'hA1);
        searchKey(8'h17);
        searchKey(8'h33);
        waitResult("b2b_a1", 1, 1'b1, 3'd3, 8'h48);
        idleCycle();
        waitResult("b2b_17", 1, 1'b1, 3'd1, 8'h42);
        waitResult("b2b_33", 1, 1'b1, 3'd6, 8'h40);

        repeat (5) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        @(negedge clk);
        checkOutput("stall_ready", 32'(bus.search_ready), 32'd0);
        checkOutput("stall_valid", 32'(bus.result_valid), 32'd1);
        checkOutput("stall_index", 32'(bus.result_index), 32'd3);
        repeat (4) idleCycle();

        applyStimulus(1'b1, 3'd2, 8'h55, 8'hFF, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        searchKey(8'h55);
        idleCycle();
        waitResult("cleared", 2, 1'b0, 3'd0, 8'h00);

        for (int c = 0; c < 400; c++) begin
            j      = $urandom_range(DEPTH - 1);
            r_we   = ($urandom_range(3) == 0);
            r_wa   = IDX_W'($urandom_range(DEPTH - 1));
            r_wv   = WIDTH'($urandom);
            r_wm   = WIDTH'($urandom) | WIDTH'($urandom);
            r_wval = ($urandom_range(3) != 0);
            r_clr  = ($urandom_range(39) == 0);
            r_sv   = ($urandom_range(3) != 0);
            r_key  = ($urandom_range(1) == 1) ? (m_value[j] ^ (WIDTH'($urandom) & ~m_mask[j]))
                                               : WIDTH'($urandom);
            r_rr   = ($urandom_range(3) != 0);
            applyStimulus(r_we, r_wa, r_wv, r_wm, r_wval, r_clr, r_sv, r_key, r_rr);
        end
        repeat (5) idleCycle();

        applyStimulus(1'b1, 3'd4, 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 3'd6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        searchKey(8'h3C);
        idleCycle();
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", 32'(bus.result_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(bus.result_valid), 32'd0);
        checkOutput("async_reset_match", 32'(bus.result_match), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        searchKey(8'h3C);
        idleCycle();
        waitResult("post_reset_3c", 2, 1'b0, 3'd0, 8'h00);
        searchKey(8'hA7);
        idleCycle();
        waitResult("post_reset_a7", 2, 1'b0, 3'd0, 8'h00);
        repeat (2) idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tcam_search_engine.md
Name: tcam_search_engine

Overview:
Parametrised ternary CAM search engine. It holds DEPTH writable rules, each made of a value, a care mask and a valid bit. Each accepted search key is compared against all rules in parallel, and the engine returns the full match vector plus the lowest-index hit through a 2-stage pipeline with valid/ready handshakes. It replaces the fixed 8x8 combinational row-match logic in the TCAM datapath.

Parameters:
WIDTH, 8, bit width of rule values, masks and search keys
DEPTH, 8, number of rule entries (>=2)
IDX_W, $clog2(DEPTH), width of entry index

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write one rule entry this cycle
wr_addr  input  IDX_W  entry index to write
wr_value  input  WIDTH  rule value
wr_mask  input  WIDTH  care mask (1 = compare bit, 0 = don't care)
wr_valid  input  1  valid bit stored with the entry (0 = invalidate)
clear_all  input  1  invalidate all entries
search_valid  input  1  search request present
search_key  input  WIDTH  key to search
search_ready  output  1  engine accepts a search this cycle
result_valid  output  1  result present
result_ready  input  1  consumer takes result
result_hit  output  1  at least one entry matched
result_index  output  IDX_W  lowest matching index (0 when no hit)
result_match  output  DEPTH  per-entry match vector, bit i = entry i

Behaviour:
- Reset (rst_n low, asynchronous): all entries have valid=0, value=0 and mask=0. Stage-1 and stage-2 valid flags clear. Outputs: result_valid=0, result_hit=0, result_index=0, result_match=0. search_ready=1 once reset is released.
- Match rule: entry i matches when valid_i is 1 and ((search_key XOR value_i) AND mask_i) == 0. An entry with mask=0 and valid=1 matches every key.
- Table update: on an edge with wr_en=1, the entry at wr_addr takes wr_value, wr_mask and wr_valid. wr_addr >= DEPTH is ignored.
- clear_all=1 clears every valid bit on that edge and has priority over wr_en on the same edge; values and masks are kept.
- Writes and clear_all are never stalled by backpressure.
- Handshake: a search is accepted on an edge where search_valid and search_ready are both 1.
- stall = result_valid AND NOT result_ready. search_ready = NOT stall.
- Stage 1 (accept edge E0): the match vector is computed from the table contents before E0 and registered together with the s1 valid flag.
- Write/search collision: a search accepted on the same edge as a write sees the old contents. A search accepted on any later edge sees the new contents.
- Stage 2 (edge E1): the priority encoder picks the lowest set bit of the stage-1 vector. result_match, result_hit and result_index are registered and result_valid goes to 1.
- Latency: result_valid is high in the cycle after E1, i.e. 2 edges after acceptance. Throughput is 1 search per cycle when result_ready stays high.
- Stall: while stall=1, stage 1 and stage 2 hold their contents and result_* stays stable.
- Stall and stage 1: a vector already in stage 1 keeps the table snapshot taken at its acceptance; later writes do not change it.
- Result consumption: result_valid drops on the edge where result_ready=1 and no new stage-1 data is advancing.
- No hit: result_hit=0, result_index=0, result_match=0.
- Multiple hits: result_index is the lowest index. result_match shows all hits.

Test Plan:
- Reset, then search key 0x5A -> after 2 cycles result_valid=1, result_hit=0, result_index=0, result_match=0x00.
- Write entry3 = value 0xA0, mask 0xF0, valid; entry6 = value 0x00, mask 0x00, valid. Search 0xA7 -> result_match=0x48, hit=1, index=3. Search 0x17 -> match=0x40, index=6.
- Same edge: write entry1 = 0x17/0xFF/valid and accept search 0x17 -> that result index=6. Next search 0x17 -> index=1, match=0x42.
- Back-to-back searches 0xA1, 0x17, 0x33 with result_ready=1 -> three results on consecutive cycles, in order, indices 3, 1, 6.
- Hold result_ready=0 for 4 cycles with search_valid=1 -> search_ready=0 after the first result is pending and result_* stays stable. Release result_ready -> no lost or duplicated result.
- clear_all asserted with wr_en to entry2 on the same edge -> all entries invalid. Then search any key -> hit=0.
- Assert rst_n low mid-pipeline -> result_valid=0 immediately (asynchronous); after release all searches miss.
